sdrc_req_gen_q: RTL

- Parametrised successor request generator between the application request port and bank control.
- Adds a request queue of configurable depth, so the application is not stalled while a split burst drains.
- Bank, row and column widths are configurable, supporting 2 or 3 bank bits and row width up to 13.
- Adds an optional programmable maximum chunk length on top of page-boundary splitting.

---
 rtl/sdrc_req_gen_q.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/sdrc_req_gen_q.sv
// Queued request generator: splits application requests into page/max-length bounded chunks for bank control.
// Optional SDRC_BANK_INTLV_EN selects the row|col|bank address map instead of row|bank|col.
module sdrc_req_gen_q #(
    parameter int APP_AW   = 30,
    parameter int APP_RW   = 9,
    parameter int REQ_ID_W = 4,
    parameter int BA_W     = 2,
    parameter int RA_W     = 13,
    parameter int QDEPTH   = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          cfg_colbits,
    input  logic [APP_RW+1:0]   cfg_max_chunk,
    input  logic [1:0]          sdr_width,
    input  logic                req,
    input  logic [REQ_ID_W-1:0] req_id,
    input  logic [APP_AW-1:0]   req_addr,
    input  logic [APP_RW-1:0]   req_len,
    input  logic                req_wr_n,
    input  logic                req_wrap,
    output logic                req_ack,
    output logic                r2x_idle,
    output logic                r2b_req,
    output logic [REQ_ID_W-1:0] r2b_req_id,
    output logic                r2b_start,
    output logic                r2b_last,
    output logic                r2b_wrap,
    output logic                r2b_write,
    output logic [BA_W-1:0]     r2b_ba,
    output logic [RA_W-1:0]     r2b_raddr,
    output logic [11:0]         r2b_caddr,
    output logic [APP_RW+1:0]   r2b_len,
    input  logic                b2r_ack,
    input  logic                b2r_arb_ok
);

    localparam int AW   = APP_AW + 2;
    localparam int LW   = APP_RW + 2;
    localparam int QPW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int QCW  = $clog2(QDEPTH + 1);
    localparam int CMPW = (LW > 13) ? LW : 13;
`ifdef SDRC_BANK_INTLV_EN
    localparam int STEP = BA_W;
`else
    localparam int STEP = 0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;
    state_t state;

    logic [REQ_ID_W-1:0] q_id    [QDEPTH];
    logic [AW-1:0]       q_addr  [QDEPTH];
    logic [LW-1:0]       q_len   [QDEPTH];
    logic                q_wrap  [QDEPTH];
    logic                q_write [QDEPTH];
    logic [QPW-1:0]      wr_ptr, rd_ptr;
    logic [QCW-1:0]      q_cnt;
    logic                q_empty, q_full, push, pop;

    logic [1:0]          s;
    logic [AW-1:0]       push_addr;
    logic [LW-1:0]       push_len;

    logic [AW-1:0]       cur_addr;
    logic [LW-1:0]       rem_len;
    logic [REQ_ID_W-1:0] cur_id;
    logic                cur_wrap, cur_write, first;

    logic [3:0]          colbits;
    logic [11:0]         col_n;
    logic [BA_W-1:0]     ba_n;
    logic [RA_W-1:0]     row_n;
    logic [12:0]         page_rem;
    logic [LW-1:0]       chunk;

    function automatic logic [QPW-1:0] next_ptr(input logic [QPW-1:0] p);
        return (p == QPW'(QDEPTH - 1)) ? '0 : p + QPW'(1);
    endfunction

    // A pop in the same cycle frees a slot, so a full queue can still accept
    assign pop      = (state == IDLE) & ~q_empty;
    assign q_empty  = (q_cnt == '0);
    assign q_full   = (q_cnt == QCW'(QDEPTH)) & ~pop;
    assign req_ack  = reset_n & req & ~q_full & b2r_arb_ok;
    assign push     = req_ack;
    assign r2x_idle = ~reset_n | (~req & q_empty & (state == IDLE));

    assign s         = sdr_width[1] ? 2'd2 : {1'b0, sdr_width[0]};
    assign push_addr = AW'(req_addr) << s;
    assign push_len  = LW'(req_len) << s;

    always_ff @(posedge clk) begin
        if (push) begin
            q_id[wr_ptr]    <= req_id;
            q_addr[wr_ptr]  <= push_addr;
            q_len[wr_ptr]   <= push_len;
            q_wrap[wr_ptr]  <= req_wrap;
            q_write[wr_ptr] <= ~req_wr_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   q_cnt <= q_cnt + QCW'(1);
                2'b01:   q_cnt <= q_cnt - QCW'(1);
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    // Address field extraction and chunk sizing for the LOAD state
    always_comb begin
        colbits  = 4'd8 + {2'b00, cfg_colbits};
        col_n    = 12'((cur_addr >> STEP) & ((AW'(1) << colbits) - AW'(1)));
`ifdef SDRC_BANK_INTLV_EN
        ba_n     = cur_addr[BA_W-1:0];
`else
        ba_n     = BA_W'(cur_addr >> colbits);
`endif
        row_n    = RA_W'(cur_addr >> (colbits + BA_W));
        page_rem = (13'd1 << colbits) - {1'b0, col_n};
        chunk    = rem_len;
        if (!cur_wrap && (CMPW'(page_rem) < CMPW'(rem_len)))
            chunk = LW'(page_rem);
        if ((cfg_max_chunk != '0) && (cfg_max_chunk < chunk))
            chunk = cfg_max_chunk;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            cur_addr   <= '0;
            rem_len    <= '0;
            cur_id     <= '0;
            cur_wrap   <= 1'b0;
            cur_write  <= 1'b0;
            first      <= 1'b0;
            r2b_req    <= 1'b0;
            r2b_req_id <= '0;
            r2b_start  <= 1'b0;
            r2b_last   <= 1'b0;
            r2b_wrap   <= 1'b0;
            r2b_write  <= 1'b0;
            r2b_ba     <= '0;
            r2b_raddr  <= '0;
            r2b_caddr  <= '0;
            r2b_len    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        cur_addr  <= q_addr[rd_ptr];
                        rem_len   <= q_len[rd_ptr];
                        cur_id    <= q_id[rd_ptr];
                        cur_wrap  <= q_wrap[rd_ptr];
                        cur_write <= q_write[rd_ptr];
                        first     <= 1'b1;
                        // zero-length requests are consumed without producing a chunk
                        state     <= (q_len[rd_ptr] == '0) ? IDLE : LOAD;
                    end
                end
                LOAD: begin
                    r2b_req    <= 1'b1;
                    r2b_req_id <= cur_id;
                    r2b_start  <= first;
                    r2b_last   <= (chunk == rem_len);
                    r2b_wrap   <= cur_wrap;
                    r2b_write  <= cur_write;
                    r2b_ba     <= ba_n;
                    r2b_raddr  <= row_n;
                    r2b_caddr  <= col_n;
                    r2b_len    <= chunk;
                    state      <= ACTIVE;
                end
                ACTIVE: begin
                    if (b2r_ack) begin
                        r2b_req <= 1'b0;
                        if (r2b_last) begin
                            state <= IDLE;
                        end else begin
                            cur_addr <= cur_addr + (AW'(r2b_len) << STEP);
                            rem_len  <= rem_len - r2b_len;
                            first    <= 1'b0;
                            state    <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
